// File: rtl/multi_dma_pkg.sv
// Shared types and helpers for the multi-channel DMA read arbiter.
// Channel/tag geometry lives here so the FIFO and top agree on widths.
package multi_dma_pkg;

  localparam int AW = 32;
  localparam int AL = 2;
  localparam int DW = 8 * (2 ** AL);
  localparam int BL = 3;
  localparam int CH = 5;
  localparam int CW = $clog2(CH + 1);
  localparam int IW = $clog2(CH);
  localparam int OD = 4;
  localparam int OW = $clog2(OD);

  typedef enum logic {
    ARB_IDLE,
    ARB_REQ
  } arb_st_e;

  typedef struct packed {
    logic [IW-1:0] ch;
    logic [BL:0]   len;
  } dma_tag_t;

  // First set bit of mask scanning upward from last+1, wrapping at CH.
  function automatic logic [IW-1:0] rr_pick(
    input logic [CH-1:0] mask,
    input logic [IW-1:0] last
  );
    logic [IW-1:0] win;
    logic          hit;
    int            j;
    win = '0;
    hit = 1'b0;
    for (int i = 1; i <= CH; i++) begin
      j = (int'(last) + i) % CH;
      if (!hit && mask[j]) begin
        win = IW'(j);
        hit = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/multi_dma_tag_fifo.sv
// In-order owner/length tags of accepted bursts.
// Push and pop in one cycle are accepted even when full.
module multi_dma_tag_fifo
  import multi_dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  dma_tag_t    din,
  output dma_tag_t    dout,
  output logic        full,
  output logic        empty,
  output logic [OW:0] occ
);

  dma_tag_t      mem [OD];
  logic [OW-1:0] wp;
  logic [OW-1:0] rp;
  logic          wr;
  logic          rd;

  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign full  = (occ == (OW+1)'(OD));
  assign empty = (occ == '0);
  assign dout  = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      unique case ({wr, rd})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

endmodule

// File: rtl/multi_dma_rd_arb.sv
// Round-robin arbiter sharing one burst-read port among CH DMA channels.
// Read beats are steered back to owners through an in-order tag FIFO.
module multi_dma_rd_arb
  import multi_dma_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CW-1:0]          nch,
  input  logic [CH-1:0]          ch_req,
  input  logic [CH-1:0][AW-1:0]  ch_adr,
  input  logic [CH-1:0][BL:0]    ch_len,
  output logic [CH-1:0]          ch_ack,
  output logic [CH-1:0]          rsp_val,
  output logic [DW-1:0]          rsp_d,
  output logic                   rsp_last,
  output logic                   err,
  input  logic                   bus_rrdy,
  output logic                   bus_rval,
  output logic [BL:0]            bus_rlen,
  output logic [AW-1:0]          bus_raddr,
  input  logic [DW-1:0]          bus_rdata,
  input  logic                   bus_rdval
);

  arb_st_e       st;
  arb_st_e       st_nx;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] last_q;
  logic [IW-1:0] win;
  logic [CH-1:0] elig;
  logic          grant;
  logic          accept;
  logic          len0;
  dma_tag_t      head;
  dma_tag_t      tag_in;
  logic          full;
  logic          empty;
  logic [OW:0]   occ;
  logic [BL:0]   bcnt;
  logic          hd_last;
  logic          hit;
  logic          pop;

  always_comb begin
    elig = '0;
    for (int i = 0; i < CH; i++) begin
      elig[i] = ch_req[i] && (CW'(i) < nch);
    end
  end

  assign win      = rr_pick(elig, last_q);
  assign grant    = (st == ARB_IDLE) && (|elig) && !full;
  assign accept   = (st == ARB_REQ) && bus_rrdy;
  assign len0     = grant && (ch_len[win] == '0);
  assign bus_rval = (st == ARB_REQ);
  assign ch_ack   = accept ? (CH'(1) << idx_q) : '0;

  always_comb begin
    st_nx = st;
    unique case (1'b1)
      (st == ARB_IDLE): if (grant) st_nx = ARB_REQ;
      (st == ARB_REQ):  if (bus_rrdy) st_nx = ARB_IDLE;
      default:          st_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ARB_IDLE;
      idx_q     <= '0;
      last_q    <= IW'(CH - 1);
      bus_raddr <= '0;
      bus_rlen  <= '0;
    end else begin
      st <= st_nx;
      if (grant) begin
        idx_q     <= win;
        bus_raddr <= ch_adr[win];
        bus_rlen  <= ch_len[win];
      end
      if (accept) last_q <= idx_q;
    end
  end

  assign tag_in = '{ch: idx_q, len: bus_rlen};

  multi_dma_tag_fifo u_tags (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .din   (tag_in),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .occ   (occ)
  );

  // A zero-length tag retires on its first beat.
  assign hd_last = (head.len == '0) || (bcnt == head.len - 1'b1);
  assign hit     = bus_rdval && !empty;
  assign pop     = hit && hd_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_val  <= '0;
      rsp_d    <= '0;
      rsp_last <= 1'b0;
      bcnt     <= '0;
      err      <= 1'b0;
    end else begin
      err <= err | len0 | (bus_rdval && empty);
      if (hit) begin
        rsp_val  <= CH'(1) << head.ch;
        rsp_d    <= bus_rdata;
        rsp_last <= hd_last;
        bcnt     <= hd_last ? '0 : bcnt + 1'b1;
      end else begin
        rsp_val  <= '0;
        rsp_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multi_dma_rd_arb.sv
// Directed bench for multi_dma_rd_arb with grant and beat scoreboards.
// Acks and beats are checked at negedge against bench-built queues.
module tb_multi_dma_rd_arb;
  import multi_dma_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [CW-1:0]         nch;
  logic [CH-1:0]         ch_req;
  logic [CH-1:0][AW-1:0] ch_adr;
  logic [CH-1:0][BL:0]   ch_len;
  logic [CH-1:0]         ch_ack;
  logic [CH-1:0]         rsp_val;
  logic [DW-1:0]         rsp_d;
  logic                  rsp_last;
  logic                  err;
  logic                  bus_rrdy;
  logic                  bus_rval;
  logic [BL:0]           bus_rlen;
  logic [AW-1:0]         bus_raddr;
  logic [DW-1:0]         bus_rdata;
  logic                  bus_rdval;

  always #5 clk = ~clk;

  multi_dma_rd_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nch       (nch),
    .ch_req    (ch_req),
    .ch_adr    (ch_adr),
    .ch_len    (ch_len),
    .ch_ack    (ch_ack),
    .rsp_val   (rsp_val),
    .rsp_d     (rsp_d),
    .rsp_last  (rsp_last),
    .err       (err),
    .bus_rrdy  (bus_rrdy),
    .bus_rval  (bus_rval),
    .bus_rlen  (bus_rlen),
    .bus_raddr (bus_raddr),
    .bus_rdata (bus_rdata),
    .bus_rdval (bus_rdval)
  );

  typedef struct {
    int ch;
    int len;
  } mtag_t;

  typedef struct {
    int            ch;
    logic [DW-1:0] d;
    bit            last;
  } beat_t;

  mtag_t mtag[$];
  beat_t sb[$];
  int    exp_gr[$];
  int    mcnt    = 0;
  int    ack_cnt = 0;
  int    ncmp    = 0;
  int    nbad    = 0;
  int    mg;
  beat_t mb;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ch_ack !== '0) begin
        if (exp_gr.size() == 0) begin
          chk("ack_unexp", 64'(ch_ack), 64'd0);
        end else begin
          mg = exp_gr.pop_front();
          chk("ack", 64'(ch_ack), 64'(1) << mg);
          ack_cnt++;
          mtag.push_back('{mg, int'(ch_len[mg])});
        end
      end
      if (rsp_val !== '0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexp", 64'(rsp_val), 64'd0);
        end else begin
          mb = sb.pop_front();
          chk("rsp_ch", 64'(rsp_val), 64'(1) << mb.ch);
          chk("rsp_d", 64'(rsp_d), 64'(mb.d));
          chk("rsp_last", 64'(rsp_last), 64'(mb.last));
        end
      end
    end
  end

  task automatic model_beat(input logic [DW-1:0] d);
    beat_t b;
    mtag_t t;
    if (mtag.size() == 0) return;
    t      = mtag[0];
    b.ch   = t.ch;
    b.d    = d;
    b.last = (t.len == 0) || (mcnt == t.len - 1);
    sb.push_back(b);
    if (b.last) begin
      t    = mtag.pop_front();
      mcnt = 0;
    end else begin
      mcnt++;
    end
  endtask

  task automatic step(input bit b);
    if (b) begin
      bus_rdval = 1'b1;
      bus_rdata = $urandom;
      model_beat(bus_rdata);
    end
    @(posedge clk);
    #1;
    bus_rdval = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (mtag.size() > 0 || sb.size() > 0); k++)
      step(mtag.size() > 0 && $urandom_range(0, 3) != 0);
    chk("drain_sb", 64'(sb.size()), 64'd0);
    chk("drain_tag", 64'(mtag.size()), 64'd0);
  endtask

  task automatic run_grants(input logic [CH-1:0] m, input int n);
    int tgt;
    tgt    = ack_cnt + n;
    ch_req = m;
    for (int k = 0; k < 300 && ack_cnt < tgt; k++)
      step(mtag.size() > 0);
    ch_req = '0;
    chk("grant_cnt", 64'(ack_cnt), 64'(tgt));
    drain();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    ch_req    = '0;
    bus_rdval = 1'b0;
    #1;
    chk("rst_rval", 64'(bus_rval), 64'd0);
    chk("rst_raddr", 64'(bus_raddr), 64'd0);
    chk("rst_rlen", 64'(bus_rlen), 64'd0);
    chk("rst_ack", 64'(ch_ack), 64'd0);
    chk("rst_rspv", 64'(rsp_val), 64'd0);
    chk("rst_rspd", 64'(rsp_d), 64'd0);
    chk("rst_last", 64'(rsp_last), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    sb.delete();
    mtag.delete();
    exp_gr.delete();
    mcnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tgt;
    rst_n     = 1'b0;
    nch       = CW'(CH);
    ch_req    = '0;
    bus_rrdy  = 1'b1;
    bus_rdata = '0;
    bus_rdval = 1'b0;
    for (int i = 0; i < CH; i++) begin
      ch_adr[i] = AW'(32'h1000 * (i + 1));
      ch_len[i] = (BL+1)'(1);
    end
    do_reset();

    // single burst on channel 0
    ch_len[0] = 4;
    exp_gr.push_back(0);
    ch_req = 5'b00001;
    step(0);
    chk("t1_rval", 64'(bus_rval), 64'd1);
    chk("t1_raddr", 64'(bus_raddr), 64'h1000);
    chk("t1_rlen", 64'(bus_rlen), 64'd4);
    ch_req = '0;
    drain();

    // round robin over 0,2,4 then with nch=3
    do_reset();
    ch_len[0] = 1;
    ch_len[2] = 2;
    ch_len[4] = 3;
    foreach (exp_gr[i]) exp_gr.delete(i);
    exp_gr = '{0, 2, 4, 0, 2, 4};
    run_grants(5'b10101, 6);
    nch    = 3;
    exp_gr = '{0, 2, 0, 2};
    run_grants(5'b10101, 4);
    nch    = CW'(CH);

    // request held while bus not ready
    bus_rrdy  = 1'b0;
    ch_len[1] = 2;
    ch_req    = 5'b00010;
    step(0);
    for (int k = 0; k < 10; k++) begin
      chk("t3_rval", 64'(bus_rval), 64'd1);
      chk("t3_raddr", 64'(bus_raddr), 64'h2000);
      chk("t3_rlen", 64'(bus_rlen), 64'd2);
      chk("t3_noack", 64'(ch_ack), 64'd0);
      step(0);
    end
    exp_gr.push_back(1);
    bus_rrdy = 1'b1;
    #1;
    chk("t3_ack", 64'(ch_ack), 64'b00010);
    ch_req = '0;
    step(0);
    drain();

    // tag FIFO full blocks grants until a pop
    for (int i = 0; i < CH; i++) ch_len[i] = 2;
    exp_gr = '{2, 3, 4, 0};
    tgt    = ack_cnt + 4;
    ch_req = '1;
    for (int k = 0; k < 40 && ack_cnt < tgt; k++) step(0);
    chk("t4_acks", 64'(ack_cnt), 64'(tgt));
    for (int k = 0; k < 6; k++) begin
      step(0);
      chk("t4_hold", 64'(bus_rval), 64'd0);
    end
    exp_gr.push_back(1);
    step(1);
    step(1);
    chk("t4_wait", 64'(bus_rval), 64'd0);
    step(0);
    chk("t4_unblk", 64'(bus_rval), 64'd1);
    chk("t4_adr", 64'(bus_raddr), 64'h2000);
    ch_req = '0;
    drain();

    // stray beat sets sticky err
    chk("t5_pre", 64'(err), 64'd0);
    bus_rdval = 1'b1;
    bus_rdata = 32'hdead_beef;
    @(posedge clk);
    #1;
    bus_rdval = 1'b0;
    chk("t5_err", 64'(err), 64'd1);
    chk("t5_norsp", 64'(rsp_val), 64'd0);
    for (int k = 0; k < 5; k++) step(0);
    chk("t5_sticky", 64'(err), 64'd1);

    // reset while a request is pending
    bus_rrdy = 1'b0;
    ch_req   = 5'b01000;
    step(0);
    chk("t6_rval", 64'(bus_rval), 64'd1);
    do_reset();
    bus_rrdy = 1'b1;
    exp_gr.push_back(0);
    run_grants(5'b01101, 1);

    // reset in the middle of beat return
    ch_len[0] = 4;
    exp_gr.push_back(0);
    tgt    = ack_cnt + 1;
    ch_req = 5'b00001;
    for (int k = 0; k < 20 && ack_cnt < tgt; k++) step(0);
    ch_req = '0;
    chk("t6_ack", 64'(ack_cnt), 64'(tgt));
    step(1);
    step(1);
    do_reset();
    exp_gr.push_back(0);
    run_grants(5'b11111, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
